// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux
// Time-multiplexed driver for a 3-digit, common-enable, active-low
// 7-segment display. The three digit codes and decimal points are
// snapshotted once per frame and shown one digit per slot, rightmost
// first. Each slot starts with a blanking interval so the segment bus
// can settle before the next enable turns on.
//
// Optional build macro:
//   LZB_EN - leading-zero blanking on the two left digits. When it is
//            undefined every digit is decoded and zeros are shown.

module sseg_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 64,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [2:0] dp_in,
  output logic [7:0] seg_n,
  output logic [2:0] en_n,
  output logic       frame_tick
);

  // Slot phase encoding: the enable is held off during BLANK and the
  // selected digit is driven during SHOW.
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam bit               HAS_BLANK = (BLANK_CYC > 0);

  localparam logic [1:0] IDX_RIGHT = 2'd0;
  localparam logic [1:0] IDX_MID   = 2'd1;
  localparam logic [1:0] IDX_LEFT  = 2'd2;

  // Segment pattern {A,B,C,D,E,F,G}, active-low, for one digit code.
  // Codes above 9 show a dash so a bad upstream value is visible.
  function automatic logic [6:0] decode7(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0001100;
      default: pat = 7'b1111110;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       sh0_q, sh1_q, sh2_q;
  logic [3:0]       sh0_d, sh1_d, sh2_d;
  logic [2:0]       shdp_q, shdp_d;
  logic [7:0]       seg_q, seg_d;
  logic [2:0]       en_q, en_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic             snap;
  logic [0:0]       phase_d;
  logic [3:0]       sel_code;
  logic             sel_dp;
  logic             blank_lead;

  // Slot counter and digit index; the index only moves when a slot ends,
  // and the frame boundary is the slot end of the leftmost digit.
  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    snap  = wrap && (idx_q == IDX_LEFT);
    cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
    idx_d = idx_q;
    if (wrap) begin
      case (idx_q)
        IDX_RIGHT: idx_d = IDX_MID;
        IDX_MID:   idx_d = IDX_LEFT;
        default:   idx_d = IDX_RIGHT;
      endcase
    end
  end

  // Shadow copies of the inputs change only at the frame boundary, so a
  // frame never mixes digits from two different input values.
  always_comb begin
    sh0_d  = sh0_q;
    sh1_d  = sh1_q;
    sh2_d  = sh2_q;
    shdp_d = shdp_q;
    if (snap) begin
      sh0_d  = digit0;
      sh1_d  = digit1;
      sh2_d  = digit2;
      shdp_d = dp_in;
    end
  end

  // Select the digit belonging to the upcoming slot from the next-state
  // shadows so the first slot of a frame already uses the new snapshot.
  always_comb begin
    sel_code = sh0_d;
    sel_dp   = shdp_d[0];
    case (idx_d)
      IDX_MID: begin
        sel_code = sh1_d;
        sel_dp   = shdp_d[1];
      end
      IDX_LEFT: begin
        sel_code = sh2_d;
        sel_dp   = shdp_d[2];
      end
      default: begin
        sel_code = sh0_d;
        sel_dp   = shdp_d[0];
      end
    endcase
  end

  // Leading-zero suppression: a left digit goes dark when it and every
  // digit to its left are zero with no decimal point; the rightmost
  // digit always shows so a value of zero is still readable.
`ifdef LZB_EN
  always_comb begin
    blank_lead = 1'b0;
    if (idx_d == IDX_LEFT) begin
      blank_lead = (sh2_d == 4'd0) && !shdp_d[2];
    end else if (idx_d == IDX_MID) begin
      blank_lead = (sh2_d == 4'd0) && (sh1_d == 4'd0) &&
                   !shdp_d[2] && !shdp_d[1];
    end
  end
`else
  always_comb begin
    blank_lead = 1'b0;
  end
`endif

  // Output next-state: blank at the start of each slot, then one enable
  // low with the decoded segments. Everything is derived from the same
  // next-state counter and index, so enables can never overlap.
  always_comb begin
    phase_d = ST_SHOW;
    if (HAS_BLANK && (cnt_d < BLANK_LIM)) begin
      phase_d = ST_BLANK;
    end
    seg_d  = 8'hFF;
    en_d   = 3'b111;
    tick_d = snap;
    if (phase_d == ST_SHOW) begin
      case (idx_d)
        IDX_RIGHT: en_d = 3'b110;
        IDX_MID:   en_d = 3'b101;
        IDX_LEFT:  en_d = 3'b011;
        default:   en_d = 3'b111;
      endcase
      if (blank_lead) begin
        seg_d = 8'hFF;
      end else begin
        seg_d = {decode7(sel_code), ~sel_dp};
      end
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= IDX_RIGHT;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Shadow digit and decimal-point registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0_q  <= 4'd0;
      sh1_q  <= 4'd0;
      sh2_q  <= 4'd0;
      shdp_q <= 3'b000;
    end else begin
      sh0_q  <= sh0_d;
      sh1_q  <= sh1_d;
      sh2_q  <= sh2_d;
      shdp_q <= shdp_d;
    end
  end

  // Registered display outputs; reset blanks the display at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= 8'hFF;
      en_q   <= 3'b111;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      en_q   <= en_d;
      tick_q <= tick_d;
    end
  end

  assign seg_n      = seg_q;
  assign en_n       = en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Testbench for sseg_scan_mux (SCAN_DIV=8, BLANK_CYC=2).
// A driver issues inputs each cycle and pushes the expected display
// state, derived from the absolute cycle number since reset, into a
// queue; a monitor pops one entry per clock and compares.

module tb_sseg_scan_mux;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 3 * SCAN_DIV;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b1111110, 7'b1111110,
    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110
  };

  typedef struct {
    logic [7:0] seg;
    logic [2:0] en;
    logic       tick;
    int         cyc;
  } expT;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit0, digit1, digit2;
  logic [2:0] dpIn;
  logic [7:0] segN;
  logic [2:0] enN;
  logic       frameTick;

  expT expQ[$];
  int  checks;
  int  errors;

  sseg_scan_mux #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .dp_in     (dpIn),
    .seg_n     (segN),
    .en_n      (enN),
    .frame_tick(frameTick)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input int cyc,
                          input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  task automatic checkOutput(input expT e);
    checkVal("seg_n", e.cyc, segN, e.seg);
    checkVal("en_n", e.cyc, {5'd0, enN}, {5'd0, e.en});
    checkVal("frame_tick", e.cyc, {7'd0, frameTick}, {7'd0, e.tick});
  endtask

  // Expected display for cycle n after reset release, given the digits
  // that were latched for the frame containing n.
  function automatic expT modelAt(input int n, input logic [3:0] s0,
                                  input logic [3:0] s1, input logic [3:0] s2,
                                  input logic [2:0] sdp);
    expT e;
    int pos, slot, off;
    logic [3:0] code;
    logic dark;
    pos  = n % FRAME;
    slot = pos / SCAN_DIV;
    off  = pos % SCAN_DIV;
    e.cyc  = n;
    e.tick = (n > 0) && (pos == 0);
    e.seg  = 8'hFF;
    e.en   = 3'b111;
    if (off >= BLANK_CYC) begin
      e.en = 3'b111 & ~(3'b001 << slot);
      code = (slot == 0) ? s0 : (slot == 1) ? s1 : s2;
      dark = 1'b0;
`ifdef LZB_EN
      if (slot == 2) dark = (s2 == 0) && !sdp[2];
      if (slot == 1) dark = (s2 == 0) && (s1 == 0) && !sdp[2] && !sdp[1];
`endif
      e.seg = dark ? 8'hFF : {SEG_TABLE[code], ~sdp[slot]};
    end
    return e;
  endfunction

  // Drives inputs for cycles 1..nCycles after a reset release. Entered
  // at a falling edge; inputs for cycle n are applied before edge n.
  task automatic applyStimulus(input int nCycles, input bit useScript);
    logic [3:0] s0, s1, s2;
    logic [2:0] sdp;
    s0 = 0; s1 = 0; s2 = 0; sdp = 0;
    for (int n = 1; n <= nCycles; n++) begin
      if (useScript) begin
        if (n < 36) begin
          digit2 = 4'd1; digit1 = 4'd2; digit0 = 4'd3; dpIn = 3'b000;
        end else if (n < 48) begin
          digit1 = 4'd7;
        end else if (n < 72) begin
          digit0 = 4'hB; dpIn = 3'b001;
        end else if (n < 96) begin
          digit2 = 4'd0; digit1 = 4'd0; digit0 = 4'd5; dpIn = 3'b000;
        end else if ($urandom_range(0, 3) == 0) begin
          digit0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          digit1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          digit2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
          dpIn   = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
        end
      end
      if (n % FRAME == 0) begin
        s0 = digit0; s1 = digit1; s2 = digit2; sdp = dpIn;
      end
      expQ.push_back(modelAt(n, s0, s1, s2, sdp));
      @(negedge clk);
    end
  endtask

  // Monitor: one expected entry per clock, sampled just after the edge.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    digit0 = 4'd3; digit1 = 4'd2; digit2 = 4'd1; dpIn = 3'b000;

    #22;
    checkVal("reset seg_n", 0, segN, 8'hFF);
    checkVal("reset en_n", 0, {5'd0, enN}, 8'b0000_0111);
    checkVal("reset frame_tick", 0, {7'd0, frameTick}, 8'd0);

    @(negedge clk);
    rst_n = 1'b1;
    // Ends at cycle 396: middle slot, inside SHOW.
    applyStimulus(396, 1'b1);
    checkVal("pre-reset en_n", 396, {5'd0, enN}, 8'b0000_0101);

    #1;
    rst_n = 1'b0;
    #1;
    checkVal("async reset seg_n", 396, segN, 8'hFF);
    checkVal("async reset en_n", 396, {5'd0, enN}, 8'b0000_0111);
    checkVal("async reset frame_tick", 396, {7'd0, frameTick}, 8'd0);
    repeat (2) @(posedge clk);
    #2;
    checkVal("held reset en_n", 0, {5'd0, enN}, 8'b0000_0111);

    digit0 = 4'd9; digit1 = 4'd8; digit2 = 4'd7; dpIn = 3'b111;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(60, 1'b0);

    checkVal("queue drained", 0, 8'(expQ.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
